// File: rtl/router_rr_pipe.sv
// NUM_IN x NUM_OUT packet router: per-output round-robin arbiter feeding a one-entry registered slot.
// Optional build macro ROUTER_DROP_CNT_EN adds a saturating counter of illegal-destination drops.
module router_rr_pipe #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 3,
  parameter int DATA_W  = 8,
  localparam int DEST_W = (NUM_OUT > 2) ? $clog2(NUM_OUT) : 1,
  localparam int SRC_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [NUM_IN*DEST_W-1:0]  in_dest,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT*SRC_W-1:0]  out_src
`ifdef ROUTER_DROP_CNT_EN
  ,
  output logic [15:0]               drop_cnt
`endif
);

  logic [NUM_IN-1:0][DEST_W-1:0]   dest;
  logic [NUM_IN-1:0]               legal;
  logic [NUM_OUT-1:0][NUM_IN-1:0]  req;
  logic [NUM_OUT-1:0]              any_req;
  logic [NUM_OUT-1:0]              load_en;
  logic [NUM_OUT-1:0]              grant;
  logic [NUM_OUT-1:0][SRC_W-1:0]   win_idx;

  logic [NUM_OUT-1:0][SRC_W-1:0]   ptr_q, ptr_d;
  logic [NUM_OUT-1:0]              out_valid_q, out_valid_d;
  logic [NUM_OUT-1:0][DATA_W-1:0]  out_data_q, out_data_d;
  logic [NUM_OUT-1:0][SRC_W-1:0]   out_src_q, out_src_d;

  always_comb begin : decode
    for (int i = 0; i < NUM_IN; i++) begin
      dest[i]  = in_dest[i*DEST_W +: DEST_W];
      legal[i] = 32'(dest[i]) < 32'(NUM_OUT);
    end
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        req[o][i] = in_valid[i] & legal[i] & (32'(dest[i]) == 32'(o));
      end
    end
  end

  // Scan from ptr+NUM_IN-1 down to ptr so the last hit is the first requester at or after ptr.
  always_comb begin : arbitrate
    int idx;
    idx = 0;
    for (int o = 0; o < NUM_OUT; o++) begin
      load_en[o] = ~out_valid_q[o] | out_ready[o];
      any_req[o] = 1'b0;
      win_idx[o] = '0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        idx = int'(ptr_q[o]) + k;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        if (req[o][idx[SRC_W-1:0]]) begin
          any_req[o] = 1'b1;
          win_idx[o] = idx[SRC_W-1:0];
        end
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the loops can infer a latch.
  always_comb begin : route
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    for (int o = 0; o < NUM_OUT; o++) begin
      grant[o] = rst_n & any_req[o] & load_en[o];
      if (grant[o]) begin
        out_valid_d[o] = 1'b1;
        out_src_d[o]   = win_idx[o];
        for (int i = 0; i < NUM_IN; i++) begin
          if (win_idx[o] == SRC_W'(i)) out_data_d[o] = in_data[i*DATA_W +: DATA_W];
        end
        ptr_d[o] = (32'(win_idx[o]) == 32'(NUM_IN - 1)) ? '0 : win_idx[o] + 1'b1;
      end else if (out_ready[o]) begin
        out_valid_d[o] = 1'b0;
      end
    end
    // Illegal destinations are always accepted and discarded; legal ones need a live grant.
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = ~legal[i];
      for (int o = 0; o < NUM_OUT; o++) begin
        if (grant[o] && win_idx[o] == SRC_W'(i)) in_ready[i] = 1'b1;
      end
    end
  end

  // NOTE: the slot payload is cleared on reset too, because out_data/out_src must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef ROUTER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_valid[i] && !legal[i]) drop_sum = drop_sum + 17'd1;
    end
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  // Default build: illegal-destination payloads are discarded without being counted.
`endif

endmodule

// File: doc/router_rr_pipe.md
ROUTER_RR_PIPE -- requirements
Module: router_rr_pipe

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, number of input ports (2..16).
REQ-002 SHALL have parameter NUM_OUT, default 3, number of output ports (2..16).
REQ-003 SHALL have parameter DATA_W, default 8, payload width in bits.
REQ-004 SHALL derive local DEST_W = max(1, clog2(NUM_OUT)) and SRC_W = max(1, clog2(NUM_IN)).
REQ-005 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have in_valid  input  NUM_IN  per-port request.
REQ-008 SHALL have in_ready  output  NUM_IN  per-port accept, combinational.
REQ-009 SHALL have in_dest  input  NUM_IN*DEST_W  per-port destination, port i at bits [i*DEST_W +: DEST_W].
REQ-010 SHALL have in_data  input  NUM_IN*DATA_W  per-port payload, same packing.
REQ-011 SHALL have out_valid  output  NUM_OUT  registered output-slot full.
REQ-012 SHALL have out_ready  input  NUM_OUT  downstream accept.
REQ-013 SHALL have out_data  output  NUM_OUT*DATA_W  registered payload per output.
REQ-014 SHALL have out_src  output  NUM_OUT*SRC_W  registered index of winning input.

Function
REQ-015 SHALL transfer on input i when in_valid[i] & in_ready[i]; on output o when out_valid[o] & out_ready[o].
REQ-016 SHALL hold, per output o, one register slot; slot may load when !out_valid[o] | out_ready[o] (load_en[o]).
REQ-017 SHALL arbitrate each output independently among inputs with in_valid and legal in_dest == o, round-robin: winner is first requester at or after ptr[o], scanning upward, wrapping NUM_IN-1 -> 0.
REQ-018 SHALL assert in_ready[i] only if i wins its destination's arbitration and load_en of that destination is 1; losers see in_ready=0 and must hold request.
REQ-019 SHALL, on grant to input i for output o, set ptr[o] = (i+1) mod NUM_IN next cycle; ptr unchanged when no grant.
REQ-020 SHALL present accepted payload on out_data/out_src with out_valid=1 exactly 1 cycle after acceptance (latency 1).
REQ-021 SHALL sustain 1 transfer/cycle/output when out_ready held high (simultaneous drain and load).
REQ-022 SHALL clear out_valid[o] after a drain with no concurrent load; hold out_data/out_src stable while out_valid & !out_ready.
REQ-023 SHALL treat in_dest >= NUM_OUT as illegal: in_ready[i]=1 same cycle, payload discarded, no output or ptr affected.
REQ-024 SHALL allow up to min(NUM_IN, NUM_OUT) grants in one cycle to distinct outputs.
REQ-025 SHALL have no combinational path from in_* to out_*; out_ready -> in_ready path permitted.

Reset
REQ-026 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_src=0, all ptr=0 asynchronously.
REQ-027 SHALL drop any in-flight slot contents on reset mid-operation; in_ready=0 for legal requests while rst_n=0.
REQ-028 SHALL resume normal arbitration on first rising clk edge after rst_n deasserts.

Configuration
REQ-029 SHALL support macro ROUTER_DROP_CNT_EN; when defined, adds output port drop_cnt (16 bits), incremented per illegal-destination transfer, saturating at 0xFFFF, reset to 0.
REQ-030 SHALL, without ROUTER_DROP_CNT_EN, omit drop_cnt entirely; all other behaviour identical.

Verification (NUM_IN=4, NUM_OUT=3, DATA_W=8)
REQ-031 SHALL cover: in0 valid dest=1 data=0xA5, out_ready=all 1 -> in_ready[0]=1 cycle 0; out_valid[1]=1, out_data[1]=0xA5, out_src[1]=0 at cycle 1.
REQ-032 SHALL cover: in0..in3 all dest=2 continuously, out_ready[2]=1 -> out_src[2] sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 SHALL cover: out_valid[0]=1, out_ready[0]=0 for 5 cycles with in1 requesting dest 0 -> in_ready[1]=0, out_data[0] stable; out_ready[0]=1 -> in_ready[1]=1 same cycle.
REQ-034 SHALL cover: in0 dest=0, in1 dest=1, in2 dest=2 same cycle -> all three in_ready=1; all three out_valid=1 next cycle.
REQ-035 SHALL cover: in3 dest=3 (illegal) for 3 transfers -> in_ready[3]=1, no out_valid change; with ROUTER_DROP_CNT_EN drop_cnt=3.
REQ-036 SHALL cover: rst_n pulsed low with out_valid=3'b111 -> out_valid=0 immediately; next grant from ptr 0.
